// File: rtl/int_ctrl.sv
// Interrupt controller: IRQ synchronisers, edge/level pending latch, enable mask,
// in-service tracking and a registered request vector for decode. Macro INT_CTRL_NESTED_EN enables priority nesting.
module int_ctrl #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic [NUM_SRC-1:0] irq_in,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    input  logic               ack_valid,
    input  logic [7:0]         ack_code,
    input  logic               rfi_valid,
    output logic [NUM_SRC-1:0] interrupts,
    output logic [NUM_SRC-1:0] in_service
);

    localparam logic [1:0] A_PENDING  = 2'd0;
    localparam logic [1:0] A_ENABLE   = 2'd1;
    localparam logic [1:0] A_EDGE_SEL = 2'd2;
    localparam logic [1:0] A_FORCE    = 2'd3;

    logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] interrupts_q, interrupts_d;
    logic [31:0]        cfg_rdata_q, cfg_rdata_d;

    logic [NUM_SRC-1:0] sync, rise, ack_oh, wr_clr, wr_force, cand, pend_edge;
    logic               ack_hit;
    logic               unused_ok;

    // One-hot of the highest set bit (highest index = highest priority).
    function automatic logic [NUM_SRC-1:0] top_bit(input logic [NUM_SRC-1:0] v);
        logic [NUM_SRC-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Bit i set when no in-service bit sits at index i or above.
    function automatic logic [NUM_SRC-1:0] above_ceiling(input logic [NUM_SRC-1:0] v);
        logic [NUM_SRC-1:0] r;
        for (int i = 0; i < NUM_SRC; i++) begin
            r[i] = ~|(v >> i);
        end
        return r;
    endfunction

    assign unused_ok = ^cfg_wdata[31:NUM_SRC];

    always_comb begin
        sync     = sync_q[SYNC_STAGES-1];
        rise     = sync & ~prev_q;
        ack_hit  = ack_valid && (ack_code[7:4] == 4'hF);
        ack_oh   = ack_hit ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << ack_code[3:0]) : '0;
        wr_clr   = (cfg_we && cfg_addr == A_PENDING) ? cfg_wdata[NUM_SRC-1:0] : '0;
        wr_force = (cfg_we && cfg_addr == A_FORCE) ? cfg_wdata[NUM_SRC-1:0] : '0;

        enable_d   = (cfg_we && cfg_addr == A_ENABLE) ? cfg_wdata[NUM_SRC-1:0] : enable_q;
        edge_sel_d = (cfg_we && cfg_addr == A_EDGE_SEL) ? cfg_wdata[NUM_SRC-1:0] : edge_sel_q;

        // Set terms are OR'd in after the clears so a coincident set wins.
        pend_edge = (pending_q & ~(wr_clr | ack_oh)) | rise | wr_force;
        pending_d = (edge_sel_q & pend_edge) | (~edge_sel_q & sync);

        cand = pending_q & enable_q;
`ifdef INT_CTRL_NESTED_EN
        in_service_d = in_service_q;
        if (rfi_valid) begin
            in_service_d = in_service_q & ~top_bit(in_service_q);
        end
        in_service_d = in_service_d | ack_oh;
        interrupts_d = cand & above_ceiling(in_service_q);
`else
        in_service_d = in_service_q;
        if (ack_hit) begin
            in_service_d = ack_oh;
        end else if (rfi_valid) begin
            in_service_d = '0;
        end
        interrupts_d = (|in_service_q) ? '0 : cand;
`endif

        cfg_rdata_d = cfg_rdata_q;
        if (cfg_re) begin
            case (cfg_addr)
                A_PENDING:  cfg_rdata_d = {{(32-NUM_SRC){1'b0}}, pending_q};
                A_ENABLE:   cfg_rdata_d = {{(32-NUM_SRC){1'b0}}, enable_q};
                A_EDGE_SEL: cfg_rdata_d = {{(32-NUM_SRC){1'b0}}, edge_sel_q};
                default:    cfg_rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q       <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            in_service_q <= '0;
            interrupts_q <= '0;
            cfg_rdata_q  <= '0;
        end else if (clk_en) begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q       <= sync;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            in_service_q <= in_service_d;
            interrupts_q <= interrupts_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign interrupts = interrupts_q;
    assign in_service = in_service_q;
    assign cfg_rdata  = cfg_rdata_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: expectations are queued with a target cycle when stimulus is driven.
module tb_int_ctrl;

    localparam int S_INT = 0;
    localparam int S_ISV = 1;
    localparam int S_RD  = 2;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clk_en, cfg_we, cfg_re, ack_valid, rfi_valid;
    logic [15:0] irq_in, interrupts, in_service;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata, cfg_rdata;
    logic [7:0]  ack_code;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int_ctrl dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .irq_in(irq_in),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .ack_valid(ack_valid), .ack_code(ack_code), .rfi_valid(rfi_valid),
        .interrupts(interrupts), .in_service(in_service)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_INT:   return {16'h0, interrupts};
            S_ISV:   return {16'h0, in_service};
            default: return cfg_rdata;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t keep[$];
        keep = {};
        foreach (sb[k]) begin
            if (sb[k].cyc <= cyc) chk(sb[k].tag, observe(sb[k].sel), sb[k].exp);
            else keep.push_back(sb[k]);
        end
        sb = keep;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_push(input int d, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.cyc = cyc + d;
        e.sel = sel;
        e.exp = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, input logic [31:0] v, input string tag);
        cfg_re = 1'b1; cfg_addr = a;
        sb_push(1, S_RD, v, tag);
        tick();
        cfg_re = 1'b0;
    endtask

    task automatic ack(input logic [7:0] code);
        ack_valid = 1'b1; ack_code = code;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; irq_in = '0; cfg_we = 0; cfg_re = 0;
        cfg_addr = '0; cfg_wdata = '0; ack_valid = 0; ack_code = '0; rfi_valid = 0;

        // Reset state
        tick(2);
        sb_push(0, S_INT, 32'h0, "rst_int");
        sb_push(0, S_ISV, 32'h0, "rst_isv");
        sb_push(0, S_RD,  32'h0, "rst_rdata");
        rst = 1'b0;
        tick();

        // Edge basic
        cfg_write(2'd1, 32'h0010);
        cfg_write(2'd2, 32'h0010);
        irq_in = 16'h0010;
        sb_push(3, S_INT, 32'h0, "edge_int_early");
        sb_push(4, S_INT, 32'h0010, "edge_int");
        tick();
        irq_in = '0;
        tick(2);
        cfg_read(2'd0, 32'h0010, "edge_pending");
        ack(8'hF4);
        sb_push(1, S_ISV, 32'h0010, "edge_ack_isv");
        sb_push(1, S_INT, 32'h0010, "edge_ack_int_lag");
        sb_push(2, S_INT, 32'h0, "edge_ack_int");
        tick();
        ack_valid = 1'b0;
        cfg_read(2'd0, 32'h0, "edge_ack_clr");
        rfi_valid = 1'b1;
        sb_push(1, S_ISV, 32'h0, "edge_rfi_isv");
        tick();
        rfi_valid = 1'b0;

        // Level hold
        cfg_write(2'd2, 32'h0);
        cfg_write(2'd1, 32'h0001);
        irq_in = 16'h0001;
        sb_push(3, S_INT, 32'h0, "lvl_int_early");
        sb_push(4, S_INT, 32'h0001, "lvl_int");
        tick(5);
        ack(8'hF0);
        sb_push(1, S_ISV, 32'h0001, "lvl_ack_isv");
        sb_push(2, S_INT, 32'h0, "lvl_blocked");
        tick();
        ack_valid = 1'b0;
        tick(2);
        cfg_read(2'd0, 32'h0001, "lvl_pend_hold");
        rfi_valid = 1'b1;
        sb_push(1, S_ISV, 32'h0, "lvl_rfi_isv");
        sb_push(1, S_INT, 32'h0, "lvl_rfi_int_lag");
        sb_push(2, S_INT, 32'h0001, "lvl_redeliver");
        tick();
        rfi_valid = 1'b0;
        tick(2);
        irq_in = '0;
        sb_push(3, S_INT, 32'h0001, "lvl_drop_early");
        sb_push(4, S_INT, 32'h0, "lvl_drop");
        tick(5);

        // Set/clear collisions on edge-mode source 2
        cfg_write(2'd2, 32'h0004);
        cfg_write(2'd1, 32'h0004);
        irq_in = 16'h0004;
        tick(2);
        cfg_write(2'd0, 32'h0004);
        sb_push(1, S_INT, 32'h0004, "w1c_vs_rise_int");
        cfg_read(2'd0, 32'h0004, "w1c_vs_rise");
        cfg_write(2'd0, 32'h0004);
        cfg_read(2'd0, 32'h0, "w1c_clear");
        irq_in = '0;
        tick(3);
        irq_in = 16'h0004;
        tick(2);
        ack(8'hF2);
        sb_push(1, S_ISV, 32'h0004, "ack_vs_rise_isv");
        tick();
        ack_valid = 1'b0;
        cfg_read(2'd0, 32'h0004, "ack_vs_rise");
        rfi_valid = 1'b1;
        sb_push(1, S_ISV, 32'h0, "coll_rfi_isv");
        tick();
        rfi_valid = 1'b0;
        irq_in = '0;
        cfg_write(2'd0, 32'h0004);

        // Config readback
        cfg_write(2'd1, 32'hFFFF_A5A5);
        cfg_read(2'd1, 32'h0000_A5A5, "rd_enable");
        cfg_we = 1'b1; cfg_re = 1'b1; cfg_addr = 2'd1; cfg_wdata = 32'h0000_1234;
        sb_push(1, S_RD, 32'h0000_A5A5, "rd_wr_same_old");
        tick();
        cfg_we = 1'b0; cfg_re = 1'b0;
        cfg_read(2'd1, 32'h0000_1234, "rd_enable_new");
        cfg_read(2'd2, 32'h0000_0004, "rd_edge_sel");
        cfg_write(2'd3, 32'h0000_FFFF);
        cfg_read(2'd3, 32'h0, "rd_force_zero");
        cfg_read(2'd0, 32'h0000_0004, "force_edge_only");
        sb_push(1, S_RD, 32'h0000_0004, "rdata_hold");
        tick();
        cfg_write(2'd0, 32'h0000_FFFF);

        // Nesting / single-level service
        cfg_write(2'd2, 32'hFFFF);
        cfg_write(2'd0, 32'hFFFF);
        cfg_write(2'd1, 32'hFFFF);
        ack(8'hF5);
        tick();
        ack_valid = 1'b0;
`ifdef INT_CTRL_NESTED_EN
        cfg_write(2'd3, 32'h0208);
        sb_push(1, S_INT, 32'h0200, "nest_above_ceiling");
        tick(2);
        ack(8'hF9);
        sb_push(1, S_ISV, 32'h0220, "nest_ack_isv");
        tick();
        ack_valid = 1'b0;
        rfi_valid = 1'b1;
        sb_push(1, S_ISV, 32'h0020, "nest_rfi1_isv");
        tick();
        rfi_valid = 1'b1;
        sb_push(1, S_INT, 32'h0, "nest_blocked");
        sb_push(1, S_ISV, 32'h0, "nest_rfi2_isv");
        sb_push(2, S_INT, 32'h0008, "nest_release");
        tick();
        rfi_valid = 1'b0;
        tick(2);
`else
        cfg_write(2'd3, 32'h0208);
        sb_push(1, S_INT, 32'h0, "single_blocked");
        tick(2);
        ack(8'hF9);
        sb_push(1, S_ISV, 32'h0200, "single_ack_replace");
        tick();
        ack_valid = 1'b0;
        rfi_valid = 1'b1;
        sb_push(1, S_ISV, 32'h0, "single_rfi_isv");
        sb_push(1, S_INT, 32'h0, "single_int_lag");
        sb_push(2, S_INT, 32'h0008, "single_release");
        tick();
        rfi_valid = 1'b0;
        tick(2);
`endif

        // clk_en freeze then reset with clk_en low
        cfg_write(2'd2, 32'h0002);
        cfg_write(2'd0, 32'hFFFF);
        cfg_write(2'd1, 32'h0002);
        tick(2);
        clk_en = 1'b0;
        irq_in = 16'h0002;
        for (int k = 1; k <= 10; k++) sb_push(k, S_INT, 32'h0, "freeze_int");
        sb_push(10, S_ISV, 32'h0, "freeze_isv");
        tick(10);
        clk_en = 1'b1;
        sb_push(3, S_INT, 32'h0, "thaw_early");
        sb_push(4, S_INT, 32'h0002, "thaw_deliver");
        tick(4);
        cfg_read(2'd1, 32'h0002, "pre_rst_enable");
        ack(8'hF1);
        sb_push(1, S_ISV, 32'h0002, "pre_rst_isv");
        tick();
        rst = 1'b1; clk_en = 1'b0; irq_in = '0;
        ack(8'hF3);
        rfi_valid = 1'b1;
        sb_push(1, S_INT, 32'h0, "rst_mid_int");
        sb_push(1, S_ISV, 32'h0, "rst_mid_isv");
        sb_push(1, S_RD,  32'h0, "rst_mid_rdata");
        tick();
        rst = 1'b0; clk_en = 1'b1; ack_valid = 1'b0; rfi_valid = 1'b0;
        sb_push(1, S_ISV, 32'h0, "post_rst_isv");
        cfg_read(2'd0, 32'h0, "post_rst_pending");
        cfg_read(2'd1, 32'h0, "post_rst_enable");
        cfg_read(2'd2, 32'h0, "post_rst_edge_sel");
        tick(3);

        foreach (sb[k]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared, want 0x%08h", sb[k].tag, sb[k].exp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
